ras_stack: RTL and testbench
============================

// Module: ras_stack
// PURPOSE
//  Return Address Stack for jalr target prediction. Consumes the push/pop/rollback strobes and the
//  ra-track write produced by the hazard/control unit. Returns the predicted return address and the
//  tracked ra-alias register. Sits beside the ID-stage jalr predictor; state is speculative and is
//  repaired on PL_flush through the rollback strobes.
// PARAMETERS
//  DEPTH  8   number of entries; power of two, >=2
//  AW     32  address width
//  PTR_W  $clog2(DEPTH)  index width (derived, do not override)
// PORTS
//  clk                   in   1      clock, rising edge
//  rst_n                 in   1      reset, asynchronous, active-low
//  RAS_push              in   1      push push_addr (jal/jalr with Rd==ra)
//  push_addr             in   AW     return address (pc+4) to push
//  RAS_pop               in   1      consume top entry (jalr predicted as return)
//  RAS_rollback_pop_id   in   1      undo a push made by the flushed ID-stage instr
//  RAS_rollback_push_id  in   1      undo a pop made by the flushed ID-stage instr
//  RAS_rollback_push_ex  in   1      undo a pop made by the flushed EX-stage instr
//  WR_ra_track_en        in   1      write ra-track register
//  WR_ra_track_data      in   5      register currently aliasing ra (`zeroreg = spilled via sw)
//  RAS_ra_track          out  5      tracked alias register
//  ras_top_addr          out  AW     predicted return address = mem[tos], combinational
//  ras_valid             out  1      count!=0
//  ras_full              out  1      count==DEPTH
// BEHAVIOUR
//  State: tos[PTR_W-1:0] (index of top entry), count[PTR_W:0], mem[DEPTH][AW], ra_track[4:0].
//  Reset (async, rst_n=0): tos=DEPTH-1, count=0, ra_track=`ra, mem contents don't-care;
//   outputs: ras_valid=0, ras_full=0, RAS_ra_track=`ra, ras_top_addr=mem[DEPTH-1] (undefined).
//  All updates on posedge clk; outputs reflect new state the following cycle (latency 1).
//  Mode select per cycle, rb = any rollback strobe:
//   rb=1      : push/pop ignored; delta = rb_push_id + rb_push_ex - rb_pop_id (range -1..+2);
//               tos += delta mod DEPTH; mem untouched (popped data is restored in place);
//               count = clamp(count+delta, 0, DEPTH).
//   push only : tos+1 mod DEPTH, mem[tos+1]=push_addr, count=min(count+1,DEPTH).
//               When full, the oldest entry is overwritten silently (circular).
//   pop only  : tos-1 mod DEPTH, count=max(count-1,0). Pop when empty: tos still moves, count stays 0.
//   push+pop  : (jalr ra,ra) replace: mem[tos]=push_addr, tos and count unchanged.
//  ras_top_addr is driven from mem[tos] regardless of ras_valid; consumers gate with ras_valid.
//  ra_track: WR_ra_track_en -> ra_track=WR_ra_track_data; else an accepted pop (pop with rb=0)
//   resets it to `ra; en and pop together -> en wins. Rollback does not alter ra_track.
//  Known, accepted inaccuracy: a push overwriting a slot later restored by rollback loses the old
//   value; no detection or recovery.
//  Reset asserted mid-operation: all state returns to reset values immediately; strobes in that
//   cycle are discarded.
// STRUCTURE
//  Constants `ra, `zeroreg and `zero come from define.v; no new shared constants.
//  One sub-module: ras_mem (DEPTH x AW register file, 1 sync write port, 1 async read port, no reset).
//  Pointer/count/ra_track logic stays in ras_stack.
// TESTING
//  1 reset; push 0x100,0x200,0x300 -> top=0x300, count=3; pop x2 -> top=0x100, valid=1.
//  2 DEPTH=8: push 9 addrs 0x10..0x90 -> full=1, top=0x90; 8 pops drain to valid=0, last top seen 0x20.
//  3 push 0xA0,0xB0; pop; rollback_push_ex -> top=0xB0, count=2; rollback_pop_id -> top=0xA0, count=1.
//  4 pop + rollback_push_id + rollback_push_ex same cycle after 2 pops -> pop ignored, tos +2.
//  5 push+pop with top=0x40 and push_addr=0x44 -> top=0x44, count unchanged.
//  6 WR_ra_track_en with data=5 -> RAS_ra_track=5; pop -> `ra; drop rst_n between edges -> state reset.

Source files
------------

// File: rtl/ras_stack_pkg.sv
// ras_stack_pkg
//   Shared constants and the per-cycle operation decode for the return
//   address stack.
//   RA_REG / ZERO_REG carry the same values as `ra / `zeroreg in define.v
//   (x1 and x0). They are repeated here so this slice builds on its own.
package ras_stack_pkg;

   localparam logic [4:0] RA_REG   = 5'd1;
   localparam logic [4:0] ZERO_REG = 5'd0;

   // One operation per cycle. A rollback outranks push/pop, because the
   // instruction that raised the push/pop is being flushed with it.
   typedef enum logic [2:0] {
      OP_HOLD     = 3'd0,
      OP_PUSH     = 3'd1,
      OP_POP      = 3'd2,
      OP_REPLACE  = 3'd3,
      OP_ROLLBACK = 3'd4
   } ras_op_e;

   function automatic ras_op_e ras_op_decode(input logic push,
                                             input logic pop,
                                             input logic rb);
      ras_op_e op;
      if (rb)               op = OP_ROLLBACK;
      else if (push && pop) op = OP_REPLACE;
      else if (push)        op = OP_PUSH;
      else if (pop)         op = OP_POP;
      else                  op = OP_HOLD;
      return op;
   endfunction

endpackage

// File: rtl/ras_mem.sv
// ras_mem
//   DEPTH x AW register file for the return address stack.
//   It has one synchronous write port and one asynchronous read port.
//   It has no reset, so its contents are undefined until written.
// Ports
//   clk    in   1      clock, rising edge
//   we     in   1      write enable
//   waddr  in   PTR_W  write index
//   wdata  in   AW     write data
//   raddr  in   PTR_W  read index
//   rdata  out  AW     mem[raddr], combinational
module ras_mem #(
   parameter int DEPTH = 8,
   parameter int AW    = 32,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  logic [AW-1:0]    wdata,
   input  logic [PTR_W-1:0] raddr,
   output logic [AW-1:0]    rdata
);

   logic [AW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ras_stack.sv
// ras_stack
//   Return address stack used to predict jalr targets. Its state is
//   speculative. When PL_flush occurs, the rollback strobes repair the
//   pointer and the count. Popped data is never erased, so a rollback
//   restores the entry in place.
//   Strobe semantics: every input strobe is a single-cycle command that is
//   sampled on the rising clock edge. There is no handshake and no
//   backpressure. The outputs show the updated state one cycle later.
// Ports
//   clk                   in   1   clock, rising edge
//   rst_n                 in   1   asynchronous active-low reset
//   RAS_push              in   1   push push_addr
//   push_addr             in   AW  return address to push
//   RAS_pop               in   1   consume the top entry
//   RAS_rollback_pop_id   in   1   undo a push made by the flushed ID instr
//   RAS_rollback_push_id  in   1   undo a pop made by the flushed ID instr
//   RAS_rollback_push_ex  in   1   undo a pop made by the flushed EX instr
//   WR_ra_track_en        in   1   write the ra-track register
//   WR_ra_track_data      in   5   register currently aliasing ra
//   RAS_ra_track          out  5   tracked alias register
//   ras_top_addr          out  AW  mem[tos], valid only when ras_valid
//   ras_valid             out  1   stack is not empty
//   ras_full              out  1   stack holds DEPTH entries
module ras_stack
   import ras_stack_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 32,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          RAS_push,
   input  logic [AW-1:0] push_addr,
   input  logic          RAS_pop,
   input  logic          RAS_rollback_pop_id,
   input  logic          RAS_rollback_push_id,
   input  logic          RAS_rollback_push_ex,
   input  logic          WR_ra_track_en,
   input  logic [4:0]    WR_ra_track_data,
   output logic [4:0]    RAS_ra_track,
   output logic [AW-1:0] ras_top_addr,
   output logic          ras_valid,
   output logic          ras_full
);

   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W+1:0] CNT_FULL_X = (PTR_W+2)'(DEPTH);

   logic [PTR_W-1:0] tos, tos_n;
   logic [PTR_W:0]   count, count_n;
   logic [4:0]       ra_track, ra_track_n;
   logic             rb;
   ras_op_e          op;

   // The rollback delta uses PTR_W+2 bit two's-complement arithmetic.
   // Its range is -1..+2, and count+delta lies in -1..DEPTH+2, so the MSB
   // of count_sum is the sign bit. The low PTR_W bits of delta give the
   // tos adjustment modulo DEPTH.
   logic [PTR_W+1:0] rb_delta, count_sum;

   logic             mem_we;
   logic [PTR_W-1:0] mem_waddr;

   assign rb = RAS_rollback_pop_id | RAS_rollback_push_id | RAS_rollback_push_ex;
   assign op = ras_op_decode(RAS_push, RAS_pop, rb);

   always_comb begin
      tos_n      = tos;
      count_n    = count;
      mem_we     = 1'b0;
      mem_waddr  = tos;
      rb_delta   = (PTR_W+2)'(RAS_rollback_push_id) + (PTR_W+2)'(RAS_rollback_push_ex)
                 - (PTR_W+2)'(RAS_rollback_pop_id);
      count_sum  = (PTR_W+2)'(count) + rb_delta;
      ra_track_n = ra_track;

      unique case (op)
         OP_ROLLBACK: begin
            tos_n = tos + rb_delta[PTR_W-1:0];
            if (count_sum[PTR_W+1])          count_n = '0;
            else if (count_sum > CNT_FULL_X) count_n = CNT_FULL;
            else                             count_n = count_sum[PTR_W:0];
         end
         OP_PUSH: begin
            // When the stack is full, this overwrites the oldest entry.
            tos_n     = tos + PTR_ONE;
            mem_we    = 1'b1;
            mem_waddr = tos + PTR_ONE;
            if (count != CNT_FULL) count_n = count + 1'b1;
         end
         OP_POP: begin
            // A pop on an empty stack still moves tos, but count stays at 0.
            tos_n = tos - PTR_ONE;
            if (count != '0) count_n = count - 1'b1;
         end
         OP_REPLACE: begin
            mem_we    = 1'b1;
            mem_waddr = tos;
         end
         default: ;
      endcase

      // A write-enable outranks the implicit clear caused by an accepted pop.
      if (WR_ra_track_en)
         ra_track_n = WR_ra_track_data;
      else if (RAS_pop && !rb)
         ra_track_n = RA_REG;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tos      <= PTR_LAST;
         count    <= '0;
         ra_track <= RA_REG;
      end else begin
         tos      <= tos_n;
         count    <= count_n;
         ra_track <= ra_track_n;
      end
   end

   // While rst_n is low, writes are blocked, so strobes in a reset cycle
   // leave the entries untouched.
   ras_mem #(.DEPTH(DEPTH), .AW(AW), .PTR_W(PTR_W)) u_mem (
      .clk   (clk),
      .we    (mem_we & rst_n),
      .waddr (mem_waddr),
      .wdata (push_addr),
      .raddr (tos),
      .rdata (ras_top_addr)
   );

   assign RAS_ra_track = ra_track;
   assign ras_valid    = (count != '0);
   assign ras_full     = (count == CNT_FULL);

endmodule

// File: tb/tb_ras_stack.sv
// tb_ras_stack
//   Self-checking bench for ras_stack (DEPTH=8, AW=32). It runs directed
//   scenarios and then a randomized strobe mix. The bench compares the DUT
//   against a stack model that uses plain integer pointers over an array.
module tb_ras_stack;
   import ras_stack_pkg::*;

   localparam int DEPTH = 8;
   localparam int AW    = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          RAS_push = 1'b0;
   logic [AW-1:0] push_addr = '0;
   logic          RAS_pop = 1'b0;
   logic          RAS_rollback_pop_id = 1'b0;
   logic          RAS_rollback_push_id = 1'b0;
   logic          RAS_rollback_push_ex = 1'b0;
   logic          WR_ra_track_en = 1'b0;
   logic [4:0]    WR_ra_track_data = '0;
   logic [4:0]    RAS_ra_track;
   logic [AW-1:0] ras_top_addr;
   logic          ras_valid;
   logic          ras_full;

   ras_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .RAS_push             (RAS_push),
      .push_addr            (push_addr),
      .RAS_pop              (RAS_pop),
      .RAS_rollback_pop_id  (RAS_rollback_pop_id),
      .RAS_rollback_push_id (RAS_rollback_push_id),
      .RAS_rollback_push_ex (RAS_rollback_push_ex),
      .WR_ra_track_en       (WR_ra_track_en),
      .WR_ra_track_data     (WR_ra_track_data),
      .RAS_ra_track         (RAS_ra_track),
      .ras_top_addr         (ras_top_addr),
      .ras_valid            (ras_valid),
      .ras_full             (ras_full)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int          m_tos;
   int          m_cnt;
   logic [31:0] m_mem [DEPTH];
   bit          m_known [DEPTH];
   logic [4:0]  m_ra;

   // Entries are still undefined after reset, so clear the known flags.
   task automatic model_reset();
      m_tos = DEPTH - 1;
      m_cnt = 0;
      m_ra  = RA_REG;
      for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
   endtask

   task automatic model_step(input bit push, input logic [31:0] addr, input bit pop,
                             input bit rpi, input bit rpid, input bit rpex,
                             input bit en, input logic [4:0] data);
      int d;
      bit rb;
      rb = rpi | rpid | rpex;
      if (rb) begin
         d = int'(rpid) + int'(rpex) - int'(rpi);
         m_tos = (m_tos + d + DEPTH) % DEPTH;
         m_cnt = m_cnt + d;
         if (m_cnt < 0) m_cnt = 0;
         if (m_cnt > DEPTH) m_cnt = DEPTH;
      end else if (push && pop) begin
         m_mem[m_tos] = addr;
         m_known[m_tos] = 1'b1;
      end else if (push) begin
         m_tos = (m_tos + 1) % DEPTH;
         m_mem[m_tos] = addr;
         m_known[m_tos] = 1'b1;
         if (m_cnt < DEPTH) m_cnt++;
      end else if (pop) begin
         m_tos = (m_tos + DEPTH - 1) % DEPTH;
         if (m_cnt > 0) m_cnt--;
      end
      if (en) m_ra = data;
      else if (pop && !rb) m_ra = RA_REG;
   endtask

   // ---------------- scoreboard ----------------
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      logic [31:0] e_top;
      check_eq({tag, ".valid"}, 32'(ras_valid), 32'(m_cnt != 0));
      check_eq({tag, ".full"},  32'(ras_full),  32'(m_cnt == DEPTH));
      check_eq({tag, ".ra"},    32'(RAS_ra_track), 32'(m_ra));
      if (m_known[m_tos]) begin
         exp_q.push_back(m_mem[m_tos]);
         e_top = exp_q.pop_front();
         check_eq({tag, ".top"}, ras_top_addr, e_top);
      end
   endtask

   // ---------------- drivers ----------------
   // Drive at the negedge, let the posedge update the DUT, then sample at
   // the next negedge.
   task automatic do_cycle(input string tag, input bit push, input logic [31:0] addr,
                           input bit pop, input bit rpi, input bit rpid, input bit rpex,
                           input bit en, input logic [4:0] data);
      RAS_push = push; push_addr = addr; RAS_pop = pop;
      RAS_rollback_pop_id = rpi; RAS_rollback_push_id = rpid; RAS_rollback_push_ex = rpex;
      WR_ra_track_en = en; WR_ra_track_data = data;
      model_step(push, addr, pop, rpi, rpid, rpex, en, data);
      @(posedge clk);
      @(negedge clk);
      RAS_push = 1'b0; RAS_pop = 1'b0; RAS_rollback_pop_id = 1'b0;
      RAS_rollback_push_id = 1'b0; RAS_rollback_push_ex = 1'b0; WR_ra_track_en = 1'b0;
      check_state(tag);
   endtask

   task automatic do_push(input string tag, input logic [31:0] a);
      do_cycle(tag, 1, a, 0, 0, 0, 0, 0, 5'd0);
   endtask

   task automatic do_pop(input string tag);
      do_cycle(tag, 0, 32'd0, 1, 0, 0, 0, 0, 5'd0);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      model_reset();
      @(negedge clk);
      apply_reset();
      check_eq("rst.valid", 32'(ras_valid), 32'd0);
      check_eq("rst.full",  32'(ras_full),  32'd0);
      check_eq("rst.ra",    32'(RAS_ra_track), 32'(RA_REG));

      // 1: basic push/pop
      do_push("t1.p", 32'h100);
      do_push("t1.p", 32'h200);
      do_push("t1.p", 32'h300);
      check_eq("t1.top3", ras_top_addr, 32'h300);
      do_pop("t1.pop");
      do_pop("t1.pop");
      check_eq("t1.top1", ras_top_addr, 32'h100);
      check_eq("t1.valid", 32'(ras_valid), 32'd1);

      // 2: overfill wraps, then drain
      apply_reset();
      for (int i = 1; i <= 9; i++) do_push("t2.p", 32'(i * 16));
      check_eq("t2.full", 32'(ras_full), 32'd1);
      check_eq("t2.top", ras_top_addr, 32'h90);
      for (int i = 0; i < 7; i++) do_pop("t2.pop");
      check_eq("t2.last_top", ras_top_addr, 32'h20);
      check_eq("t2.valid7", 32'(ras_valid), 32'd1);
      do_pop("t2.pop8");
      check_eq("t2.empty", 32'(ras_valid), 32'd0);
      do_pop("t2.pop_empty");
      check_eq("t2.still_empty", 32'(ras_valid), 32'd0);

      // 3: rollback restores a popped entry, then undoes a push
      apply_reset();
      do_push("t3.p", 32'hA0);
      do_push("t3.p", 32'hB0);
      do_pop("t3.pop");
      do_cycle("t3.rbex", 0, 32'd0, 0, 0, 0, 1, 0, 5'd0);
      check_eq("t3.top_b0", ras_top_addr, 32'hB0);
      do_cycle("t3.rbpi", 0, 32'd0, 0, 1, 0, 0, 0, 5'd0);
      check_eq("t3.top_a0", ras_top_addr, 32'hA0);
      check_eq("t3.valid", 32'(ras_valid), 32'd1);

      // 4: pop ignored under a double rollback
      apply_reset();
      do_push("t4.p", 32'h1);
      do_push("t4.p", 32'h2);
      do_push("t4.p", 32'h3);
      do_pop("t4.pop");
      do_pop("t4.pop");
      do_cycle("t4.rb2", 0, 32'd0, 1, 0, 1, 1, 0, 5'd0);
      check_eq("t4.top", ras_top_addr, 32'h3);

      // 5: push+pop replaces the top
      apply_reset();
      do_push("t5.p", 32'h40);
      do_cycle("t5.repl", 1, 32'h44, 1, 0, 0, 0, 0, 5'd0);
      check_eq("t5.top", ras_top_addr, 32'h44);
      check_eq("t5.valid", 32'(ras_valid), 32'd1);

      // 6: ra-track write, then pop clears it, and en beats pop
      do_cycle("t6.wr", 0, 32'd0, 0, 0, 0, 0, 1, 5'd5);
      check_eq("t6.ra5", 32'(RAS_ra_track), 32'd5);
      do_pop("t6.pop");
      check_eq("t6.ra_clr", 32'(RAS_ra_track), 32'(RA_REG));
      do_cycle("t6.en_pop", 0, 32'd0, 1, 0, 0, 0, 1, ZERO_REG);
      check_eq("t6.en_wins", 32'(RAS_ra_track), 32'(ZERO_REG));
      do_cycle("t6.rb_keep", 0, 32'd0, 1, 0, 1, 0, 0, 5'd0);
      check_eq("t6.rb_keeps", 32'(RAS_ra_track), 32'(ZERO_REG));

      // 6b: async reset between edges, with strobes that must be discarded
      do_push("t6.p", 32'h77);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_eq("t6.async_valid", 32'(ras_valid), 32'd0);
      check_eq("t6.async_ra", 32'(RAS_ra_track), 32'(RA_REG));
      RAS_push = 1'b1; push_addr = 32'h55; WR_ra_track_en = 1'b1; WR_ra_track_data = 5'd9;
      @(posedge clk);
      @(negedge clk);
      RAS_push = 1'b0; WR_ra_track_en = 1'b0;
      check_eq("t6.rst_discard_valid", 32'(ras_valid), 32'd0);
      check_eq("t6.rst_discard_ra", 32'(RAS_ra_track), 32'(RA_REG));
      rst_n = 1'b1;
      @(negedge clk);
      check_state("t6.post_rst");

      // Randomized phase
      for (int i = 0; i < 600; i++) begin
         bit push, pop, rpi, rpid, rpex, en;
         bit [3:0] rnd;
         rnd  = 4'($urandom_range(0, 15));
         push = ($urandom_range(0, 99) < 45);
         pop  = ($urandom_range(0, 99) < 35);
         rpi = 0; rpid = 0; rpex = 0;
         if (rnd == 0) begin
            rpi  = 1'($urandom_range(0, 1));
            rpid = 1'($urandom_range(0, 1));
            rpex = 1'($urandom_range(0, 1));
         end
         en = ($urandom_range(0, 9) == 0);
         do_cycle("rand", push, $urandom, pop, rpi, rpid, rpex, en,
                  5'($urandom_range(0, 31)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
